plot_scheduler: RTL and testbench
=================================

# plot_scheduler

Sequences every pixel write to the `vga_adapter` plot port. Per game tick it plots the four player heads and the countdown-bar pixel. When the round ends it sweeps the 160x120 frame to black, then plots the winner marker. It sits between the movement, timer and score logic and the single VGA write port, and is the only block that drives `x`, `y`, `colour` and `plot`.

## Interface
Parameters:
- `SCREEN_W`, 160: frame width in pixels.
- `SCREEN_H`, 120: frame height in pixels.
- `TIMER_ROW`, 119: y coordinate of the countdown bar.
- `WIN_X`, 85: x coordinate of the winner marker.
- `WIN_Y`, 42: y coordinate of the winner marker.

Ports:
- `CLOCK_50`, in, 1: the only clock.
- `reset`, in, 1: synchronous, active-high.
- `tick`, in, 1: one-cycle pulse on each game movement step.
- `timer_tick`, in, 1: one-cycle pulse on each countdown step.
- `p1`, `p2`, `p3`, `p4`, in, 15 each: player positions; x is [14:7], y is [6:0].
- `winner`, in, 2: winning player index, 0 to 3.
- `x`, out, 8: plot x coordinate.
- `y`, out, 7: plot y coordinate.
- `colour`, out, 3: plot colour.
- `plot`, out, 1: write strobe for the VGA adapter.
- `running`, out, 1: high while the round is live.
- `clear_done`, out, 1: high once the end-of-round sweep has finished.

## Operation
States: `IDLE`, `DRAW_P1`, `DRAW_P2`, `DRAW_P3`, `DRAW_P4`, `DRAW_TIMER`, `CLEAR`, `WINNER`, `HALT`.

Normal play:
- In `IDLE` with `running`=1 and a tick pending, the FSM steps `DRAW_P1` → `DRAW_P2` → `DRAW_P3` → `DRAW_P4` → `DRAW_TIMER` → `IDLE`.
- Each of these five states lasts one cycle and issues exactly one `plot` pulse.

Colours:
- P1 `001`, P2 `010`, P3 `100`, P4 `110`.
- Timer pixel `111`.
- Clear `000`.
- Winner marker uses the player colour selected by `winner`.

Countdown bar:
- 8-bit `timer_x` increments on each `timer_tick` while `running`=1.
- `DRAW_TIMER` plots (`timer_x`, `TIMER_ROW`).
- When `timer_x` reaches `SCREEN_W-1` on an increment, `running` clears on the next cycle and stays low until reset.

Tick handling:
- A one-deep `tick_pending` flag sets on `tick` and clears on the `IDLE`→`DRAW_P1` transition.
- A second tick arriving while one is already pending is dropped.

End of round:
- In `IDLE` with `running`=0, the FSM enters `CLEAR`.
- `CLEAR` visits every pixel in raster order: (0,0), (1,0) … (159,0), (0,1) … (159,119).
- One `plot` is issued per cycle, 19200 cycles total.
- After (159,119) the FSM goes to `WINNER`, which issues one `plot` at (`WIN_X`, `WIN_Y`), then to `HALT`.
- In `HALT`: `plot`=0 and `clear_done`=1, held until reset.

## Timing
Reset values:
- State `IDLE`, `running`=1, `clear_done`=0.
- `plot`=0, `x`=0, `y`=0, `colour`=0.
- `timer_x`=0, `tick_pending`=0, sweep counters 0.

Latency:
- All outputs are registered.
- A `tick` seen in `IDLE` on cycle N gives the P1 plot on cycle N+2: pending flag at N+1, draw at N+2.
- The P1→timer plots then fill cycles N+2 to N+6.

Positions:
- `p1`..`p4` are sampled in the cycle their draw state is entered.
- Changing positions mid-sequence affects only players not yet drawn.

Boundary cases:
- `running` falling mid-sequence: the current five-pixel sequence completes, then `CLEAR` starts.
- `tick` and `timer_tick` in the same cycle: both take effect.
- Ticks during `CLEAR`, `WINNER` or `HALT`: ignored, and `tick_pending` is forced to 0.
- Sweep counters wrap x at `SCREEN_W-1` and increment y.
- `plot` is never high for x ≥ `SCREEN_W` or y ≥ `SCREEN_H`.
- `reset` asserted in any state, including mid-`CLEAR`: all registers return to reset values on the next edge, and no `plot` is issued in that cycle.

## Structure
- Shared package `tron_pkg` holds:
  - the colour constants `COL_P1` to `COL_P4`, `COL_TIMER`, `COL_BLACK`;
  - the screen dimensions;
  - the FSM state encoding.
- One sub-module, `clear_sweeper`: raster x/y counter with `start`, `busy`, `last` and `x`/`y` outputs, instantiated for `CLEAR`.
- The FSM, tick latch and timer counter stay in `plot_scheduler`.

## Test plan
- Reset, then one `tick` with p1=(10,20), p2=(30,40), p3=(50,60), p4=(70,80):
  - exactly 5 `plot` pulses on consecutive cycles;
  - coordinates/colours (10,20,001), (30,40,010), (50,60,100), (70,80,110), (0,119,111);
  - then `plot`=0.
- Three `tick` pulses within one five-cycle draw sequence: exactly two sequences are drawn (10 plots).
- 159 `timer_tick` pulses: `running` falls one cycle after `timer_x`=159.
  - The last timer plot before `running` falls is at (159,119).
  - Exactly 19200 black plots follow, the first at (0,0) and the last at (159,119).
- After the sweep with `winner`=2:
  - one plot at (85,42) colour `100`;
  - then `clear_done`=1 and `plot`=0 for 1000 cycles;
  - further ticks produce no plots.
- `reset` asserted at sweep pixel (40,7):
  - next cycle state is `IDLE`, `plot`=0, `running`=1, `timer_x`=0;
  - a subsequent `tick` draws the normal five-pixel sequence.

Source files
------------

// File: rtl/tron_pkg.sv
// Shared definitions for the tron display path: frame size, plot colours,
// scheduler state encoding and the packed player-position layout.
package tron_pkg;

  localparam int FRAME_W = 160;
  localparam int FRAME_H = 120;

  localparam logic [2:0] COL_P1    = 3'b001;
  localparam logic [2:0] COL_P2    = 3'b010;
  localparam logic [2:0] COL_P3    = 3'b100;
  localparam logic [2:0] COL_P4    = 3'b110;
  localparam logic [2:0] COL_TIMER = 3'b111;
  localparam logic [2:0] COL_BLACK = 3'b000;

  localparam logic [3:0] IDLE       = 4'd0;
  localparam logic [3:0] DRAW_P1    = 4'd1;
  localparam logic [3:0] DRAW_P2    = 4'd2;
  localparam logic [3:0] DRAW_P3    = 4'd3;
  localparam logic [3:0] DRAW_P4    = 4'd4;
  localparam logic [3:0] DRAW_TIMER = 4'd5;
  localparam logic [3:0] CLEAR      = 4'd6;
  localparam logic [3:0] WINNER     = 4'd7;
  localparam logic [3:0] HALT       = 4'd8;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
  } pos_t;

  function automatic logic [2:0] player_colour(input logic [1:0] idx);
    case (idx)
      2'd0:    return COL_P1;
      2'd1:    return COL_P2;
      2'd2:    return COL_P3;
      default: return COL_P4;
    endcase
  endfunction

endpackage

// File: rtl/clear_sweeper.sv
// Raster x/y walker for the end-of-round wipe: x,y is the next pixel to issue; one step per cycle once started.
// Never stalls; last pulses for one cycle after the final pixel (W-1,H-1) has been handed out.
module clear_sweeper
  import tron_pkg::*;
#(
  parameter int W = FRAME_W,
  parameter int H = FRAME_H
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       last,
  output logic [7:0] x,
  output logic [6:0] y
);

  localparam logic [7:0] X_MAX = 8'(W - 1);
  localparam logic [6:0] Y_MAX = 7'(H - 1);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      busy <= 1'b0;
      last <= 1'b0;
      x    <= 8'd0;
      y    <= 7'd0;
    end else begin
      last <= 1'b0;
      if (start || busy) begin
        busy <= 1'b1;
        if (x == X_MAX) begin
          x <= 8'd0;
          // Counters park at (0,0) so the next start begins a fresh frame.
          if (y == Y_MAX) begin
            y    <= 7'd0;
            busy <= 1'b0;
            last <= 1'b1;
          end else begin
            y <= y + 7'd1;
          end
        end else begin
          x <= x + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/plot_scheduler.sv
// Sole driver of the VGA plot port: five-pixel draw per tick, then black sweep and winner marker at round end.
// Registered outputs, P1 plot two cycles after a tick; no backpressure, one spare tick is latched, extras dropped.
module plot_scheduler
  import tron_pkg::*;
#(
  parameter int SCREEN_W  = FRAME_W,
  parameter int SCREEN_H  = FRAME_H,
  parameter int TIMER_ROW = 119,
  parameter int WIN_X     = 85,
  parameter int WIN_Y     = 42
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        tick,
  input  logic        timer_tick,
  input  logic [14:0] p1,
  input  logic [14:0] p2,
  input  logic [14:0] p3,
  input  logic [14:0] p4,
  input  logic [1:0]  winner,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        running,
  output logic        clear_done
);

  localparam logic [7:0] X_MAX = 8'(SCREEN_W - 1);

  logic [3:0] state;
  logic [7:0] timer_x;
  logic       tick_pending;
  logic       sw_start, sw_busy, sw_last;
  logic [7:0] sw_x;
  logic [6:0] sw_y;
  pos_t       cur_pos;
  logic [2:0] cur_col;
  logic       start_draw, end_phase;

  clear_sweeper #(.W(SCREEN_W), .H(SCREEN_H)) u_sweeper (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .start    (sw_start),
    .busy     (sw_busy),
    .last     (sw_last),
    .x        (sw_x),
    .y        (sw_y)
  );

  // Position/colour of the player plotted on the edge leaving the current state.
  always_comb begin
    cur_pos = p1;
    cur_col = COL_P1;
    case (state)
      DRAW_P1: begin cur_pos = p2; cur_col = COL_P2; end
      DRAW_P2: begin cur_pos = p3; cur_col = COL_P3; end
      DRAW_P3: begin cur_pos = p4; cur_col = COL_P4; end
      default: ;
    endcase
  end

  assign sw_start   = (state == IDLE) && !running;
  assign start_draw = (state == IDLE) && running && tick_pending;
  assign end_phase  = (state == CLEAR) || (state == WINNER) || (state == HALT);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state        <= IDLE;
      running      <= 1'b1;
      clear_done   <= 1'b0;
      plot         <= 1'b0;
      x            <= 8'd0;
      y            <= 7'd0;
      colour       <= 3'd0;
      timer_x      <= 8'd0;
      tick_pending <= 1'b0;
    end else begin
      plot    <= 1'b0;
      running <= running && (timer_x != X_MAX);
      // Holding at the right edge keeps the timer pixel on screen.
      if (timer_tick && running && (timer_x != X_MAX))
        timer_x <= timer_x + 8'd1;

      if (end_phase)       tick_pending <= 1'b0;
      else if (tick)       tick_pending <= 1'b1;
      else if (start_draw) tick_pending <= 1'b0;

      case (state)
        IDLE: begin
          if (!running) begin
            state  <= CLEAR;
            plot   <= 1'b1;
            x      <= sw_x;
            y      <= sw_y;
            colour <= COL_BLACK;
          end else if (tick_pending) begin
            state  <= DRAW_P1;
            plot   <= 1'b1;
            x      <= cur_pos.x;
            y      <= cur_pos.y;
            colour <= cur_col;
          end
        end
        DRAW_P1, DRAW_P2, DRAW_P3: begin
          state  <= (state == DRAW_P1) ? DRAW_P2 : (state == DRAW_P2) ? DRAW_P3 : DRAW_P4;
          plot   <= 1'b1;
          x      <= cur_pos.x;
          y      <= cur_pos.y;
          colour <= cur_col;
        end
        DRAW_P4: begin
          state  <= DRAW_TIMER;
          plot   <= 1'b1;
          x      <= timer_x;
          y      <= 7'(TIMER_ROW);
          colour <= COL_TIMER;
        end
        DRAW_TIMER: state <= IDLE;
        CLEAR: begin
          if (sw_last) begin
            state  <= WINNER;
            plot   <= 1'b1;
            x      <= 8'(WIN_X);
            y      <= 7'(WIN_Y);
            colour <= player_colour(winner);
          end else begin
            plot   <= sw_busy;
            x      <= sw_x;
            y      <= sw_y;
            colour <= COL_BLACK;
          end
        end
        WINNER: begin
          state      <= HALT;
          clear_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_plot_scheduler.sv
// Directed phases plus randomized tick/position traffic, checked against a tick-scheduling
// reference model that predicts every plot event (cycle, x, y, colour).
module tb_plot_scheduler;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic        timer_tick = 1'b0;
  logic [14:0] p1 = '0, p2 = '0, p3 = '0, p4 = '0;
  logic [1:0]  winner = 2'd2;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot, running, clear_done;

  always #5 CLOCK_50 = ~CLOCK_50;

  plot_scheduler dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .tick       (tick),
    .timer_tick (timer_tick),
    .p1         (p1),
    .p2         (p2),
    .p3         (p3),
    .p4         (p4),
    .winner     (winner),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .running    (running),
    .clear_done (clear_done)
  );

  localparam int MAXW = 512;

  typedef struct {
    int t;
    int x;
    int y;
    int c;
  } ev_t;

  int          tests = 0;
  int          fails = 0;
  int          tbase = 0;
  bit          tk [MAXW];
  bit          ttk [MAXW];
  bit          run_obs [MAXW];
  logic [14:0] pw [MAXW][4];
  ev_t         obs_q[$];
  ev_t         exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  function automatic logic [14:0] mkpos(input int px, input int py);
    return 15'((px << 7) | py);
  endfunction

  task automatic set_window(input logic [14:0] a, input logic [14:0] b,
                            input logic [14:0] c, input logic [14:0] d);
    for (int i = 0; i < MAXW; i++) begin
      tk[i]    = 1'b0;
      ttk[i]   = 1'b0;
      pw[i][0] = a;
      pw[i][1] = b;
      pw[i][2] = c;
      pw[i][3] = d;
    end
  endtask

  task automatic run_window(input int n);
    obs_q.delete();
    for (int i = 0; i < n; i++) begin
      tick       = tk[i];
      timer_tick = ttk[i];
      p1 = pw[i][0];
      p2 = pw[i][1];
      p3 = pw[i][2];
      p4 = pw[i][3];
      step();
      run_obs[i] = running;
      if (plot === 1'b1) obs_q.push_back(ev_t'{i, int'(x), int'(y), int'(colour)});
    end
    tick       = 1'b0;
    timer_tick = 1'b0;
  endtask

  // Sequence-level model: a draw may start one cycle after a latched tick and
  // no sooner than six cycles after the previous start; a tick arriving while
  // a start is still pending is lost.
  task automatic model_window(input int n);
    int starts[$];
    int pend, last, tv, s;
    int col[5];
    col = '{1, 2, 4, 6, 7};
    exp_q.delete();
    pend = -1;
    last = -100;
    for (int t = 0; t < n; t++) begin
      if (tk[t]) begin
        if (pend >= 0 && t < pend) continue;
        if (pend >= 0) begin
          starts.push_back(pend);
          last = pend;
        end
        pend = (t + 1 > last + 6) ? t + 1 : last + 6;
      end
    end
    if (pend >= 0) starts.push_back(pend);
    foreach (starts[j]) begin
      s  = starts[j];
      tv = tbase;
      for (int t = 0; t < s + 4; t++) if (ttk[t] && tv < 159) tv++;
      for (int k = 0; k < 4; k++)
        exp_q.push_back(ev_t'{s + k, int'(pw[s + k][k] >> 7), int'(pw[s + k][k] & 15'h7f), col[k]});
      exp_q.push_back(ev_t'{s + 4, tv, 119, 7});
    end
    for (int t = 0; t < n; t++) if (ttk[t] && tbase < 159) tbase++;
  endtask

  task automatic compare(input string tag);
    int m;
    check({tag, ".count"}, obs_q.size(), exp_q.size());
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s[%0d].t", tag, i), obs_q[i].t, exp_q[i].t);
      check($sformatf("%s[%0d].x", tag, i), obs_q[i].x, exp_q[i].x);
      check($sformatf("%s[%0d].y", tag, i), obs_q[i].y, exp_q[i].y);
      check($sformatf("%s[%0d].c", tag, i), obs_q[i].c, exp_q[i].c);
    end
  endtask

  int ex [5][4];
  int r, black, bad, gap, wi, wx, wy, wc, hi_cnt, done_lo;
  bit found;

  initial begin
    // Reset state
    step();
    step();
    reset = 1'b0;
    check("rst.plot", plot, 0);
    check("rst.x", x, 0);
    check("rst.y", y, 0);
    check("rst.colour", colour, 0);
    check("rst.running", running, 1);
    check("rst.clear_done", clear_done, 0);

    // One tick, fixed positions
    set_window(mkpos(10, 20), mkpos(30, 40), mkpos(50, 60), mkpos(70, 80));
    tk[0] = 1'b1;
    run_window(14);
    model_window(14);
    compare("seq1");
    ex = '{'{1, 10, 20, 1}, '{2, 30, 40, 2}, '{3, 50, 60, 4}, '{4, 70, 80, 6}, '{5, 0, 119, 7}};
    check("seq1.n_lit", obs_q.size(), 5);
    for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
      check($sformatf("seq1.lit%0d.t", i), obs_q[i].t, ex[i][0]);
      check($sformatf("seq1.lit%0d.x", i), obs_q[i].x, ex[i][1]);
      check($sformatf("seq1.lit%0d.y", i), obs_q[i].y, ex[i][2]);
      check($sformatf("seq1.lit%0d.c", i), obs_q[i].c, ex[i][3]);
    end

    // Extra ticks during a draw: only one is kept
    set_window(mkpos(1, 2), mkpos(3, 4), mkpos(5, 6), mkpos(7, 8));
    tk[0] = 1'b1;
    tk[2] = 1'b1;
    tk[4] = 1'b1;
    run_window(24);
    model_window(24);
    compare("burst");
    check("burst.n_lit", obs_q.size(), 10);

    // Random ticks, timer ticks and per-cycle positions
    set_window('0, '0, '0, '0);
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 4; k++) pw[i][k] = mkpos($urandom_range(0, 159), $urandom_range(0, 119));
      if (i < 288) begin
        tk[i]  = ($urandom_range(0, 3) == 0);
        ttk[i] = ($urandom_range(0, 9) == 0);
      end
    end
    run_window(300);
    model_window(300);
    compare("rand");

    // Countdown to the end, with a tick on the final timer step
    set_window(mkpos(11, 12), mkpos(13, 14), mkpos(15, 16), mkpos(17, 18));
    r = 159 - tbase;
    for (int i = 0; i < r; i++) ttk[i] = 1'b1;
    tk[r - 1] = 1'b1;
    run_window(r + 6);
    model_window(r + 6);
    compare("final");
    check("final.run_at_159", run_obs[r - 1], 1);
    check("final.run_fall", run_obs[r], 0);
    if (obs_q.size() > 0) begin
      check("final.timer_x", obs_q[obs_q.size() - 1].x, 159);
      check("final.timer_y", obs_q[obs_q.size() - 1].y, 119);
    end

    // Black sweep then winner marker; ticks must be ignored throughout
    black = 0; bad = 0; gap = 0; wi = -1; wx = -1; wy = -1; wc = -1;
    for (int i = 0; i < 19400 && wi < 0; i++) begin
      tick = ($urandom_range(0, 3) == 0);
      step();
      if (plot === 1'b1 && colour === 3'd0) begin
        if (i != black) gap++;
        if (x !== 8'(black % 160) || y !== 7'(black / 160)) bad++;
        black++;
      end else if (plot === 1'b1) begin
        wi = i; wx = int'(x); wy = int'(y); wc = int'(colour);
      end
    end
    tick = 1'b0;
    check("sweep.count", black, 19200);
    check("sweep.order_bad", bad, 0);
    check("sweep.gaps", gap, 0);
    check("winner.cycle", wi, 19200);
    check("winner.x", wx, 85);
    check("winner.y", wy, 42);
    check("winner.colour", wc, 4);

    hi_cnt = 0; done_lo = 0;
    for (int i = 0; i < 1000; i++) begin
      tick = ($urandom_range(0, 2) == 0);
      step();
      if (plot !== 1'b0) hi_cnt++;
      if (clear_done !== 1'b1) done_lo++;
    end
    tick = 1'b0;
    check("halt.plots", hi_cnt, 0);
    check("halt.done_low", done_lo, 0);

    // Reset in the middle of a sweep
    reset = 1'b1;
    step();
    reset = 1'b0;
    tbase = 0;
    timer_tick = 1'b1;
    for (int i = 0; i < 159; i++) step();
    timer_tick = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      step();
      if (plot === 1'b1 && x === 8'd40 && y === 7'd7) found = 1'b1;
    end
    check("midrst.found", found, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst.plot", plot, 0);
    check("midrst.running", running, 1);
    check("midrst.clear_done", clear_done, 0);
    check("midrst.x", x, 0);
    check("midrst.y", y, 0);
    check("midrst.colour", colour, 0);
    step();
    check("midrst.idle_plot", plot, 0);

    set_window(mkpos(10, 20), mkpos(30, 40), mkpos(50, 60), mkpos(70, 80));
    tk[0] = 1'b1;
    run_window(14);
    model_window(14);
    compare("after_rst");
    if (obs_q.size() == 5) check("after_rst.timer_x", obs_q[4].x, 0);
    else check("after_rst.n_lit", obs_q.size(), 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
